rx_pkt_parser: RTL and testbench



---
 rtl/rx_pkt_pkg.sv | 30 +++
 rtl/rx_pkt_timeout.sv | 36 +++
 rtl/rx_pkt_parser.sv | 173 +++++++++++++++++
 tb/tb_rx_pkt_parser.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkt_pkg.sv
// Shared types and constants for the UART packet receiver.
package rx_pkt_pkg;

   typedef enum logic [2:0] {
      S_SYNC,
      S_CMD,
      S_LEN,
      S_DATA,
      S_CHK,
      S_DROP
   } state_t;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_LEN  = 2'b01;
   localparam logic [1:0] ERR_CHK  = 2'b10;
   localparam logic [1:0] ERR_TMO  = 2'b11;

   localparam int CHK_SUM = 0;
   localparam int CHK_XOR = 1;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < value) r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rx_pkt_timeout.sv
// Inter-byte idle counter: a byte strobe loads 1, clr holds it at 0,
// otherwise it counts up and saturates at TIMEOUT_CYC-1 (expire).
module rx_pkt_timeout
   import rx_pkt_pkg::*;
#(
   parameter int TIMEOUT_CYC = 10000,
   parameter int CNT_W       = clog2(TIMEOUT_CYC) + 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic load,
   output logic expire
);

   localparam logic [CNT_W-1:0] LAST    = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic [CNT_W-1:0] cnt_reg;

   // The strobe cycle itself counts as the first idle cycle, hence the load of 1.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= CNT_ONE;
      end else if (clr) begin
         cnt_reg <= '0;
      end else if (cnt_reg != LAST) begin
         cnt_reg <= cnt_reg + CNT_ONE;
      end
   end

   assign expire = (cnt_reg == LAST);

endmodule

// File: rtl/rx_pkt_parser.sv
// Frame parser: [SYNC] CMD LEN PAYLOAD[LEN] CHK from a UART byte stream,
// payload written to a buffer, one done/error pulse per frame.
module rx_pkt_parser
   import rx_pkt_pkg::*;
#(
   parameter int         MAX_LEN     = 256,
   parameter int         ADDR_W      = clog2(MAX_LEN),
   parameter int         SYNC_EN     = 1,
   parameter logic [7:0] SYNC_BYTE   = 8'hA5,
   parameter int         CHK_MODE    = 0,
   parameter int         TIMEOUT_CYC = 10000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_done,
   output logic              pck_done,
   output logic              pck_err,
   output logic [1:0]        err_code,
   output logic              busy,
   output logic [7:0]        cmd_rx,
   output logic [ADDR_W:0]   len_rx,
   output logic [7:0]        wr_data,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              we
);

   localparam state_t            START     = (SYNC_EN != 0) ? S_SYNC : S_CMD;
   localparam logic [8:0]        MAX_LEN_9 = 9'(MAX_LEN);
   localparam logic [ADDR_W:0]   LEN_ONE   = 1;
   localparam logic [ADDR_W-1:0] CNT_ONE   = 1;

   state_t            state_reg, state_next;
   logic [7:0]        chk_reg, chk_next;
   logic [ADDR_W-1:0] cnt_reg, cnt_next;
   logic [7:0]        cmd_reg, cmd_next;
   logic [ADDR_W:0]   len_reg, len_next;
   logic [7:0]        wr_data_reg, wr_data_next;
   logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
   logic              we_reg, we_next;
   logic              done_reg, done_next;
   logic              err_reg, err_next;
   logic [1:0]        code_reg, code_next;
   logic [8:0]        len_dec;
   logic              chk_ok;
   logic              last_byte;
   logic              at_start;
   logic              expire;

   function automatic logic [7:0] chk_upd(input logic [7:0] acc, input logic [7:0] b);
      logic [7:0] r;
      if (CHK_MODE == CHK_XOR) r = acc ^ b;
      else                     r = acc + b;
      return r;
   endfunction

   assign at_start  = (state_reg == START);
   assign len_dec   = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
   assign chk_ok    = (CHK_MODE == CHK_XOR) ? (rx_data == chk_reg) : (rx_data == ~chk_reg);
   assign last_byte = ({1'b0, cnt_reg} == (len_reg - LEN_ONE));

   rx_pkt_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (at_start),
      .load    (rx_done),
      .expire  (expire)
   );

   always_comb begin
      state_next   = state_reg;
      chk_next     = chk_reg;
      cnt_next     = cnt_reg;
      cmd_next     = cmd_reg;
      len_next     = len_reg;
      wr_data_next = wr_data_reg;
      wr_addr_next = wr_addr_reg;
      we_next      = 1'b0;
      done_next    = 1'b0;
      err_next     = 1'b0;
      code_next    = code_reg;
      if (rx_done) begin
         case (state_reg)
            S_SYNC: begin
               if (rx_data == SYNC_BYTE) state_next = S_CMD;
            end
            S_CMD: begin
               cmd_next   = rx_data;
               chk_next   = rx_data;
               state_next = S_LEN;
            end
            S_LEN: begin
               if (len_dec > MAX_LEN_9) begin
                  err_next   = 1'b1;
                  code_next  = ERR_LEN;
                  state_next = S_DROP;
               end else begin
                  len_next   = len_dec[ADDR_W:0];
                  chk_next   = chk_upd(chk_reg, rx_data);
                  cnt_next   = '0;
                  state_next = S_DATA;
               end
            end
            S_DATA: begin
               wr_data_next = rx_data;
               wr_addr_next = cnt_reg;
               we_next      = 1'b1;
               cnt_next     = cnt_reg + CNT_ONE;
               chk_next     = chk_upd(chk_reg, rx_data);
               if (last_byte) state_next = S_CHK;
            end
            S_CHK: begin
               if (chk_ok) begin
                  done_next = 1'b1;
               end else begin
                  err_next  = 1'b1;
                  code_next = ERR_CHK;
               end
               state_next = START;
            end
            default: ;
         endcase
      end else if (expire && !at_start) begin
         // A frame already rejected for length leaves S_DROP silently.
         if (state_reg != S_DROP) begin
            err_next  = 1'b1;
            code_next = ERR_TMO;
         end
         state_next = START;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg   <= START;
         chk_reg     <= '0;
         cnt_reg     <= '0;
         cmd_reg     <= '0;
         len_reg     <= '0;
         wr_data_reg <= '0;
         wr_addr_reg <= '0;
         we_reg      <= 1'b0;
         done_reg    <= 1'b0;
         err_reg     <= 1'b0;
         code_reg    <= ERR_NONE;
      end else begin
         state_reg   <= state_next;
         chk_reg     <= chk_next;
         cnt_reg     <= cnt_next;
         cmd_reg     <= cmd_next;
         len_reg     <= len_next;
         wr_data_reg <= wr_data_next;
         wr_addr_reg <= wr_addr_next;
         we_reg      <= we_next;
         done_reg    <= done_next;
         err_reg     <= err_next;
         code_reg    <= code_next;
      end
   end

   assign pck_done = done_reg;
   assign pck_err  = err_reg;
   assign err_code = code_reg;
   assign busy     = !at_start;
   assign cmd_rx   = cmd_reg;
   assign len_rx   = len_reg;
   assign wr_data  = wr_data_reg;
   assign wr_addr  = wr_addr_reg;
   assign we       = we_reg;

endmodule

// File: tb/tb_rx_pkt_parser.sv
// Directed bench: dut0 (MAX_LEN=16, sync, sum checksum), dut1 (MAX_LEN=256, no sync, XOR);
// expected writes and pulses are queued at stimulus time and popped by per-DUT monitors.
module tb_rx_pkt_parser;

   localparam int T0 = 40;
   localparam int T1 = 64;

   typedef struct packed {
      logic [8:0] addr;
      logic [7:0] data;
   } wr_t;

   typedef struct packed {
      logic       is_err;
      logic [1:0] code;
      logic [7:0] cmd;
      logic [8:0] len;
      int         at;
   } pulse_t;

   logic       clk;
   logic       reset_n;
   logic [7:0] rx_data;
   logic       rx_done0, rx_done1;

   logic       pck_done_0, pck_err_0, busy_0, we_0;
   logic [1:0] err_code_0;
   logic [7:0] cmd_rx_0, wr_data_0;
   logic [4:0] len_rx_0;
   logic [3:0] wr_addr_0;

   logic       pck_done_1, pck_err_1, busy_1, we_1;
   logic [1:0] err_code_1;
   logic [7:0] cmd_rx_1, wr_data_1;
   logic [8:0] len_rx_1;
   logic [7:0] wr_addr_1;

   int     total = 0;
   int     bad = 0;
   int     cyc = 0;
   int     last_strobe = 0;
   wr_t    wr_q[2][$];
   pulse_t pulse_q[2][$];

   rx_pkt_parser #(
      .MAX_LEN (16), .SYNC_EN (1), .SYNC_BYTE (8'hA5), .CHK_MODE (0), .TIMEOUT_CYC (T0)
   ) dut0 (
      .clk (clk), .reset_n (reset_n), .rx_data (rx_data), .rx_done (rx_done0),
      .pck_done (pck_done_0), .pck_err (pck_err_0), .err_code (err_code_0), .busy (busy_0),
      .cmd_rx (cmd_rx_0), .len_rx (len_rx_0), .wr_data (wr_data_0), .wr_addr (wr_addr_0),
      .we (we_0)
   );

   rx_pkt_parser #(
      .MAX_LEN (256), .SYNC_EN (0), .SYNC_BYTE (8'hA5), .CHK_MODE (1), .TIMEOUT_CYC (T1)
   ) dut1 (
      .clk (clk), .reset_n (reset_n), .rx_data (rx_data), .rx_done (rx_done1),
      .pck_done (pck_done_1), .pck_err (pck_err_1), .err_code (err_code_1), .busy (busy_1),
      .cmd_rx (cmd_rx_1), .len_rx (len_rx_1), .wr_data (wr_data_1), .wr_addr (wr_addr_1),
      .we (we_1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic mon(input int id, input logic we, input logic [8:0] addr, input logic [7:0] data,
                      input logic done, input logic err, input logic [1:0] code,
                      input logic [7:0] cmd, input logic [8:0] len);
      wr_t    w;
      pulse_t p;
      if (we) begin
         check($sformatf("d%0d_wr_expected", id), 32'(wr_q[id].size() != 0), 32'd1);
         if (wr_q[id].size() != 0) begin
            w = wr_q[id].pop_front();
            check($sformatf("d%0d_wr_addr", id), 32'(addr), 32'(w.addr));
            check($sformatf("d%0d_wr_data", id), 32'(data), 32'(w.data));
            $display("d%0d write addr=%0d data=%02h", id, addr, data);
         end
      end
      if (done || err) begin
         check($sformatf("d%0d_pulse_excl", id), 32'(done & err), 32'd0);
         check($sformatf("d%0d_pulse_expected", id), 32'(pulse_q[id].size() != 0), 32'd1);
         if (pulse_q[id].size() != 0) begin
            p = pulse_q[id].pop_front();
            check($sformatf("d%0d_pulse_kind", id), 32'(err), 32'(p.is_err));
            check($sformatf("d%0d_pulse_cycle", id), 32'(cyc), 32'(p.at));
            if (p.is_err) begin
               check($sformatf("d%0d_err_code", id), 32'(code), 32'(p.code));
            end else begin
               check($sformatf("d%0d_cmd_rx", id), 32'(cmd), 32'(p.cmd));
               check($sformatf("d%0d_len_rx", id), 32'(len), 32'(p.len));
            end
            $display("d%0d pulse done=%0b err=%0b code=%0d cyc=%0d", id, done, err, code, cyc);
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, we_0, {5'b0, wr_addr_0}, wr_data_0, pck_done_0, pck_err_0, err_code_0,
          cmd_rx_0, {4'b0, len_rx_0});
      mon(1, we_1, {1'b0, wr_addr_1}, wr_data_1, pck_done_1, pck_err_1, err_code_1,
          cmd_rx_1, len_rx_1);
   end

   // Drives one byte for exactly one cycle; consecutive calls are back-to-back strobes.
   task automatic send(input int id, input logic [7:0] b);
      rx_data = b;
      if (id == 0) rx_done0 = 1'b1;
      else         rx_done1 = 1'b1;
      @(posedge clk);
      #1;
      last_strobe = cyc;
      rx_done0 = 1'b0;
      rx_done1 = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic frame0(input logic [7:0] cmd, input int n, input logic [7:0] base,
                         input logic corrupt);
      logic [7:0] sum;
      logic [7:0] d;
      pulse_t     p;
      send(0, 8'hA5);
      send(0, cmd);
      sum = cmd;
      send(0, 8'(n));
      sum = sum + 8'(n);
      for (int i = 0; i < n; i++) begin
         d = base + 8'(i);
         wr_q[0].push_back('{addr: 9'(i), data: d});
         send(0, d);
         sum = sum + d;
      end
      send(0, corrupt ? (~sum ^ 8'h01) : ~sum);
      if (corrupt) p = '{is_err: 1'b1, code: 2'b10, cmd: 8'h00, len: 9'd0, at: last_strobe};
      else         p = '{is_err: 1'b0, code: 2'b00, cmd: cmd, len: 9'(n), at: last_strobe};
      pulse_q[0].push_back(p);
   endtask

   initial begin
      logic [7:0] x;
      reset_n  = 1'b0;
      rx_data  = 8'h00;
      rx_done0 = 1'b0;
      rx_done1 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs0", {1'b0, pck_done_0, pck_err_0, err_code_0, busy_0, cmd_rx_0,
                               len_rx_0, wr_data_0, wr_addr_0, we_0}, 32'd0);
      check("reset_outputs1", 32'(|{pck_done_1, pck_err_1, err_code_1, busy_1, cmd_rx_1,
                                   len_rx_1, wr_data_1, wr_addr_1, we_1}), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      idle(2);

      // 1: A5 10 03 01 02 03 E6
      frame0(8'h10, 3, 8'h01, 1'b0);
      idle(3);
      check("t1_cmd_rx", 32'(cmd_rx_0), 32'h10);
      check("t1_len_rx", 32'(len_rx_0), 32'd3);
      check("t1_busy_after", 32'(busy_0), 32'd0);

      // 2: bad checksum then a good frame; err_code must hold across the good frame
      frame0(8'h10, 3, 8'h01, 1'b1);
      idle(3);
      check("t2_err_code", 32'(err_code_0), 32'd2);
      frame0(8'h22, 4, 8'h40, 1'b0);
      idle(3);
      check("t2_err_code_held", 32'(err_code_0), 32'd2);

      // 3: LEN=0x20 exceeds MAX_LEN=16; remaining bytes dropped until timeout
      send(0, 8'hA5);
      send(0, 8'h01);
      send(0, 8'h20);
      pulse_q[0].push_back('{is_err: 1'b1, code: 2'b01, cmd: 8'h00, len: 9'd0, at: last_strobe});
      for (int i = 0; i < 5; i++) send(0, 8'(8'h60 + i));
      check("t3_busy_drop", 32'(busy_0), 32'd1);
      idle(T0 + 5);
      check("t3_busy_after", 32'(busy_0), 32'd0);
      frame0(8'h33, 2, 8'h90, 1'b0);
      idle(3);

      // 4: timeout inside the payload
      send(0, 8'hA5);
      send(0, 8'h02);
      send(0, 8'h04);
      wr_q[0].push_back('{addr: 9'd0, data: 8'hAA});
      send(0, 8'hAA);
      wr_q[0].push_back('{addr: 9'd1, data: 8'hBB});
      send(0, 8'hBB);
      pulse_q[0].push_back('{is_err: 1'b1, code: 2'b11, cmd: 8'h00, len: 9'd0,
                             at: last_strobe + T0 - 1});
      check("t4_busy_mid", 32'(busy_0), 32'd1);
      idle(T0 + 5);
      check("t4_busy_after", 32'(busy_0), 32'd0);
      check("t4_err_code_held", 32'(err_code_0), 32'd3);

      // 5: dut1, LEN=00 (256 bytes), XOR checksum
      send(1, 8'h5C);
      x = 8'h5C;
      send(1, 8'h00);
      for (int i = 0; i < 256; i++) begin
         wr_q[1].push_back('{addr: 9'(i), data: 8'(i)});
         send(1, 8'(i));
         x = x ^ 8'(i);
      end
      send(1, x);
      pulse_q[1].push_back('{is_err: 1'b0, code: 2'b00, cmd: 8'h5C, len: 9'd256, at: last_strobe});
      idle(3);
      check("t5_len_rx", 32'(len_rx_1), 32'd256);
      check("t5_busy_after", 32'(busy_1), 32'd0);

      // 6: reset during payload, then garbage before SYNC and a full frame
      send(0, 8'hA5);
      send(0, 8'h07);
      send(0, 8'h05);
      wr_q[0].push_back('{addr: 9'd0, data: 8'h11});
      send(0, 8'h11);
      wr_q[0].push_back('{addr: 9'd1, data: 8'h12});
      send(0, 8'h12);
      idle(2);
      check("t6_busy_before_reset", 32'(busy_0), 32'd1);
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("t6_reset_outputs0", {1'b0, pck_done_0, pck_err_0, err_code_0, busy_0, cmd_rx_0,
                                  len_rx_0, wr_data_0, wr_addr_0, we_0}, 32'd0);
      check("t6_reset_outputs1", 32'(|{pck_done_1, pck_err_1, err_code_1, busy_1, cmd_rx_1,
                                      len_rx_1, wr_data_1, wr_addr_1, we_1}), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      idle(T0 + 2);
      check("t6_no_pulse_after_reset", 32'(err_code_0), 32'd0);
      send(0, 8'h00);
      send(0, 8'hFF);
      check("t6_garbage_ignored", 32'(busy_0), 32'd0);
      frame0(8'h44, 5, 8'hF0, 1'b0);
      idle(3);
      check("t6_cmd_rx", 32'(cmd_rx_0), 32'h44);

      idle(5);
      check("end_wr_q0_empty", 32'(wr_q[0].size()), 32'd0);
      check("end_wr_q1_empty", 32'(wr_q[1].size()), 32'd0);
      check("end_pulse_q0_empty", 32'(pulse_q[0].size()), 32'd0);
      check("end_pulse_q1_empty", 32'(pulse_q[1].size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
